dlatch_write_ctrl: RTL and testbench

Upstream driver stage for the team's level-sensitive D-latch bank (UDP D-latch cells, ports q/en/d). It accepts a data word over a valid/ready handshake and presents it on the latch d inputs. It then opens the latch enable for a programmable window with guaranteed setup and hold cycles. Clocked logic paces every latch write, so the transparent phase never overlaps a data change.

---
 rtl/dlatch_write_ctrl_pkg.sv | 18 +
 rtl/dlatch_write_ctrl_cyc_down_counter.sv | 40 ++++
 rtl/dlatch_write_ctrl.sv | 140 ++++++++++++++
 tb/tb_dlatch_write_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dlatch_write_ctrl_pkg.sv
// Shared types and default timing for the D-latch bank write controller.
package dlatch_write_ctrl_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_CNT_W     = 8;

  // The encoding is fixed so that state values read the same in every tool.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/dlatch_write_ctrl_cyc_down_counter.sv
// Loadable down-counter with a zero flag. It times the SETUP, OPEN and HOLD
// phases of a latch write.
module dlatch_write_ctrl_cyc_down_counter
  import dlatch_write_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes priority over decrement. The count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dlatch_write_ctrl.sv
// Write sequencer for the level-sensitive D-latch bank. It captures a word
// over valid/ready and drives it onto lat_d. It then opens lat_en for a
// fixed window, with setup and hold margins timed from clk.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a word; in_ready high; lat_d keeps last value
// SETUP   | lat_d driven and stable, lat_en still low
// OPEN    | lat_en high, so the latch is transparent
// HOLD    | lat_en low again; lat_d held for the latch hold margin
module dlatch_write_ctrl
  import dlatch_write_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow_q
);

  // Each phase loads the counter with its length minus one, so the phase
  // lasts exactly *_CYC cycles including the cycle in which it was entered.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shadow_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  dlatch_write_ctrl_cyc_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and next-output logic. lat_d changes only on an accept in IDLE.
  always_comb begin
    state_d      = state_q;
    lat_d_d      = lat_d_q;
    lat_en_d     = lat_en_q;
    done_d       = 1'b0;
    shadow_d     = shadow_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          lat_d_d      = in_data;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          lat_en_d     = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
          state_d      = ST_OPEN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_OPEN: begin
        if (cnt_zero) begin
          lat_en_d = 1'b0;
          // The latch holds whatever was on d when the enable closes.
          shadow_d = lat_d_q;
          if (HOLD_CYC == 0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LD;
            state_d      = ST_HOLD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs. Reset closes the latch at once and drops any done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = ~in_ready;
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dlatch_write_ctrl.sv
// Directed bench for dlatch_write_ctrl. It uses a default-timing instance and
// a short-pulse instance with no hold phase.
module tb_dlatch_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid2;
  logic [7:0] in_data, in_data2;
  logic       in_ready, lat_en, busy, done;
  logic [7:0] lat_d, shadow_q;
  logic       in_ready2, lat_en2, busy2, done2;
  logic [7:0] lat_d2, shadow_q2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlatch_write_ctrl #(
    .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lat_d(lat_d), .lat_en(lat_en), .busy(busy),
    .done(done), .shadow_q(shadow_q)
  );

  dlatch_write_ctrl #(
    .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(0), .CNT_W(8)
  ) dut_short (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .lat_d(lat_d2), .lat_en(lat_en2), .busy(busy2),
    .done(done2), .shadow_q(shadow_q2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; in_data2 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({lat_en, lat_d, shadow_q, in_ready, busy, done} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: en=%b d=%h sh=%h rdy=%b busy=%b done=%b, expected 0 00 00 1 0 0",
               lat_en, lat_d, shadow_q, in_ready, busy, done);
    end
    checks++;
    if ({lat_en2, lat_d2, shadow_q2, in_ready2, busy2, done2} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_short: en=%b d=%h sh=%h rdy=%b busy=%b done=%b, expected 0 00 00 1 0 0",
               lat_en2, lat_d2, shadow_q2, in_ready2, busy2, done2);
    end
    tick();
    checks++;
    if ({lat_en, in_ready, done} !== 3'b010) begin
      errors++;
      $display("FAIL reset_idle: en=%b rdy=%b done=%b, expected 0 1 0", lat_en, in_ready, done);
    end
  endtask

  task automatic test_single_write();
    logic       en_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       rdy_exp[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       dn_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] sh_exp [6] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5};
    in_valid = 1'b1; in_data = 8'hA5;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) in_valid = 1'b0;
      checks++;
      if ({lat_en, in_ready, busy, done, lat_d, shadow_q} !==
          {en_exp[k], rdy_exp[k], ~rdy_exp[k], dn_exp[k], 8'hA5, sh_exp[k]}) begin
        errors++;
        $display("FAIL single_write edge%0d: en=%b rdy=%b busy=%b done=%b d=%h sh=%h, expected %b %b %b %b a5 %h",
                 k, lat_en, in_ready, busy, done, lat_d, shadow_q,
                 en_exp[k], rdy_exp[k], ~rdy_exp[k], dn_exp[k], sh_exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       en_exp [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rdy_exp[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] d_exp  [10] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
    logic [7:0] sh_exp [10] = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hC3, 8'hC3};
    in_valid = 1'b1; in_data = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) in_data = 8'hC3;
      if (k == 5) in_valid = 1'b0;
      checks++;
      if ({lat_en, in_ready, done, lat_d, shadow_q} !==
          {en_exp[k], rdy_exp[k], rdy_exp[k], d_exp[k], sh_exp[k]}) begin
        errors++;
        $display("FAIL back_to_back edge%0d: en=%b rdy=%b done=%b d=%h sh=%h, expected %b %b %b %h %h",
                 k, lat_en, in_ready, done, lat_d, shadow_q,
                 en_exp[k], rdy_exp[k], rdy_exp[k], d_exp[k], sh_exp[k]);
      end
    end
  endtask

  task automatic test_busy_reject();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_data = 8'hFF;
    for (int k = 1; k < 5; k++) begin
      tick();
      checks++;
      if (lat_d !== 8'hA5) begin
        errors++;
        $display("FAIL busy_reject edge%0d: lat_d=%h, expected a5", k, lat_d);
      end
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({lat_d, in_ready} !== {8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL busy_reject accept: lat_d=%h rdy=%b, expected ff 0", lat_d, in_ready);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({in_ready, done, shadow_q} !== {1'b1, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL busy_reject drain: rdy=%b done=%b sh=%h, expected 1 1 ff", in_ready, done, shadow_q);
    end
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({lat_en, lat_d} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL mid_pulse open: en=%b d=%h, expected 1 77", lat_en, lat_d);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({lat_en, lat_d, shadow_q, in_ready, busy, done} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_pulse reset: en=%b d=%h sh=%h rdy=%b busy=%b done=%b, expected 0 00 00 1 0 0",
               lat_en, lat_d, shadow_q, in_ready, busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({lat_en, done, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL mid_pulse after%0d: en=%b done=%b rdy=%b, expected 0 0 1", k, lat_en, done, in_ready);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic       en_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       rdy_exp[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       dn_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] sh_exp [4] = '{8'h00, 8'h00, 8'h5A, 8'h5A};
    in_valid2 = 1'b1; in_data2 = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) in_valid2 = 1'b0;
      checks++;
      if ({lat_en2, in_ready2, busy2, done2, lat_d2, shadow_q2} !==
          {en_exp[k], rdy_exp[k], ~rdy_exp[k], dn_exp[k], 8'h5A, sh_exp[k]}) begin
        errors++;
        $display("FAIL short_pulse edge%0d: en=%b rdy=%b busy=%b done=%b d=%h sh=%h, expected %b %b %b %b 5a %h",
                 k, lat_en2, in_ready2, busy2, done2, lat_d2, shadow_q2,
                 en_exp[k], rdy_exp[k], ~rdy_exp[k], dn_exp[k], sh_exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_pulse();
    test_short_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
